// File: rtl/afe_multich_calib_ctrl_pkg.sv
// Purpose: shared FSM state type, default thresholds and a width helper for the AFE calibration controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package afe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DC_WIN   = 3'd1,
        ST_DC_EVAL  = 3'd2,
        ST_PGA_WIN  = 3'd3,
        ST_PGA_EVAL = 3'd4,
        ST_NEXT_CH  = 3'd5,
        ST_RUN      = 3'd6,
        ST_FAIL     = 3'd7
    } afe_state_t;

    localparam int AFE_N_CH     = 2;
    localparam int AFE_ADC_W    = 8;
    localparam int AFE_DC_W     = 7;
    localparam int AFE_PGA_W    = 4;
    localparam int AFE_WIN_LEN  = 1000;
    localparam int AFE_SLOT_LEN = 10;
    localparam int AFE_DC_INIT  = 127;
    localparam int AFE_DC_LO    = 120;
    localparam int AFE_DC_HI    = 135;
    localparam int AFE_DC_DN    = 5;
    localparam int AFE_DC_UP    = 2;
    localparam int AFE_CLIP_LO  = 10;
    localparam int AFE_CLIP_HI  = 245;
    localparam int AFE_MAX_ITER = 64;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int afe_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/afe_multich_calib_ctrl_win_minmax.sv
// Purpose: running min/max over a window of WIN_LEN enabled ADC samples.
// Latency: min/max include the sample taken on the edge where done is high; visible the next cycle.
// Backpressure: none; a sample is absorbed on every enabled cycle.
module win_minmax
    import afe_pkg::*;
#(
    parameter int ADC_W   = AFE_ADC_W,
    parameter int WIN_LEN = AFE_WIN_LEN
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] min_val,
    output logic [ADC_W-1:0] max_val,
    output logic             done
);

    localparam int               CNT_W    = afe_clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // done marks the enabled sample that completes the window
    assign done = en && (cnt == CNT_LAST);

    // min/max tracking and sample counting; clear restores the empty-window extremes
    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            min_val <= '1;
            max_val <= '0;
            cnt     <= '0;
        end else if (en) begin
            if (sample < min_val) begin
                min_val <= sample;
            end
            if (sample > max_val) begin
                max_val <= sample;
            end
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/afe_multich_calib_ctrl.sv
// Purpose: per-channel DC-comp then PGA calibration from windowed ADC min/max, then LED time-multiplexing in RUN.
// Latency: each window is WIN_LEN cycles plus one eval cycle; first CH_Valid[0] SLOT_LEN cycles after RUN entry.
// Backpressure: none; ADC is consumed every cycle and outputs are never throttled.
module afe_multich_calib_ctrl
    import afe_pkg::*;
#(
    parameter int N_CH     = AFE_N_CH,
    parameter int ADC_W    = AFE_ADC_W,
    parameter int DC_W     = AFE_DC_W,
    parameter int PGA_W    = AFE_PGA_W,
    parameter int WIN_LEN  = AFE_WIN_LEN,
    parameter int SLOT_LEN = AFE_SLOT_LEN,
    parameter int DC_INIT  = AFE_DC_INIT,
    parameter int DC_LO    = AFE_DC_LO,
    parameter int DC_HI    = AFE_DC_HI,
    parameter int DC_DN    = AFE_DC_DN,
    parameter int DC_UP    = AFE_DC_UP,
    parameter int CLIP_LO  = AFE_CLIP_LO,
    parameter int CLIP_HI  = AFE_CLIP_HI,
    parameter int MAX_ITER = AFE_MAX_ITER,
    localparam int CH_W    = afe_clog2(N_CH)
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [ADC_W-1:0]      ADC,
    input  logic                  Find_setting,
    output logic [N_CH-1:0]       LED_EN,
    output logic [DC_W-1:0]       DC_Comp,
    output logic [PGA_W-1:0]      PGA_Gain,
    output logic                  CLK_Filter,
    output logic [N_CH*ADC_W-1:0] CH_ADC_Value,
    output logic [N_CH-1:0]       CH_Valid,
    output logic                  Calib_done,
    output logic                  Calib_fail,
    output logic [CH_W-1:0]       Fail_ch
);

    localparam int ITER_W = afe_clog2(MAX_ITER + 1);
    localparam int SLOT_W = afe_clog2(SLOT_LEN);

    localparam logic [ADC_W:0]    MID_LO    = (ADC_W + 1)'(DC_LO);
    localparam logic [ADC_W:0]    MID_HI    = (ADC_W + 1)'(DC_HI);
    localparam logic [ADC_W-1:0]  CLIP_LO_V = ADC_W'(CLIP_LO);
    localparam logic [ADC_W-1:0]  CLIP_HI_V = ADC_W'(CLIP_HI);
    localparam logic [DC_W-1:0]   DC_INIT_V = DC_W'(DC_INIT);
    localparam logic [DC_W-1:0]   DC_DN_V   = DC_W'(DC_DN);
    localparam logic [DC_W-1:0]   DC_UP_V   = DC_W'(DC_UP);
    localparam logic [DC_W-1:0]   DC_MAX    = '1;
    localparam logic [PGA_W-1:0]  PGA_MAX   = '1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);

    afe_state_t state, state_nxt;

    logic [CH_W-1:0]       ch, ch_nxt;
    logic [DC_W-1:0]       dc_reg, dc_nxt;
    logic [PGA_W-1:0]      pga_reg, pga_nxt;
    logic [ITER_W-1:0]     iter, iter_nxt;
    logic [N_CH*DC_W-1:0]  dc_store, dc_store_nxt;
    logic [N_CH*PGA_W-1:0] pga_store, pga_store_nxt;
    logic [CH_W-1:0]       fail_ch, fail_ch_nxt;
    logic [CH_W-1:0]       run_ch, run_ch_nxt;
    logic [SLOT_W-1:0]     slot_cnt, slot_nxt;
    logic [N_CH*ADC_W-1:0] ch_val, ch_val_nxt;
    logic [N_CH-1:0]       ch_vld, ch_vld_nxt;
    logic                  clk_filt;

    logic                  in_win;
    logic                  win_en;
    logic                  win_clr;
    logic                  win_done;
    logic [ADC_W-1:0]      win_min;
    logic [ADC_W-1:0]      win_max;
    logic [ADC_W:0]        mid;
    logic                  clip;

    // The window only accumulates while an LED is lit for calibration; anything else empties it.
    assign in_win  = (state == ST_DC_WIN) || (state == ST_PGA_WIN);
    assign win_en  = in_win && !Find_setting;
    assign win_clr = !in_win || Find_setting;

    win_minmax #(
        .ADC_W   (ADC_W),
        .WIN_LEN (WIN_LEN)
    ) u_win (
        .CLK     (CLK),
        .rst     (rst),
        .clr     (win_clr),
        .en      (win_en),
        .sample  (ADC),
        .min_val (win_min),
        .max_val (win_max),
        .done    (win_done)
    );

    // Midpoint carries one extra bit so max+min cannot wrap.
    assign mid  = ({1'b0, win_max} + {1'b0, win_min}) >> 1;
    assign clip = (win_min < CLIP_LO_V) || (win_max > CLIP_HI_V);

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= ST_IDLE;
            ch        <= '0;
            dc_reg    <= DC_INIT_V;
            pga_reg   <= '0;
            iter      <= '0;
            dc_store  <= '0;
            pga_store <= '0;
            fail_ch   <= '0;
            run_ch    <= '0;
            slot_cnt  <= '0;
            ch_val    <= '0;
            ch_vld    <= '0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            dc_reg    <= dc_nxt;
            pga_reg   <= pga_nxt;
            iter      <= iter_nxt;
            dc_store  <= dc_store_nxt;
            pga_store <= pga_store_nxt;
            fail_ch   <= fail_ch_nxt;
            run_ch    <= run_ch_nxt;
            slot_cnt  <= slot_nxt;
            ch_val    <= ch_val_nxt;
            ch_vld    <= ch_vld_nxt;
        end
    end

    // Filter clock runs at CLK/2 regardless of calibration state
    always_ff @(posedge CLK) begin
        if (rst) begin
            clk_filt <= 1'b0;
        end else begin
            clk_filt <= ~clk_filt;
        end
    end

    // Next-state and datapath updates; a restart request overrides every state
    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        dc_nxt        = dc_reg;
        pga_nxt       = pga_reg;
        iter_nxt      = iter;
        dc_store_nxt  = dc_store;
        pga_store_nxt = pga_store;
        fail_ch_nxt   = fail_ch;
        run_ch_nxt    = run_ch;
        slot_nxt      = slot_cnt;
        ch_val_nxt    = ch_val;
        ch_vld_nxt    = '0;

        if (Find_setting) begin
            state_nxt  = ST_DC_WIN;
            ch_nxt     = '0;
            dc_nxt     = DC_INIT_V;
            pga_nxt    = '0;
            iter_nxt   = '0;
            run_ch_nxt = '0;
            slot_nxt   = '0;
        end else begin
            case (state)
                ST_DC_WIN: begin
                    if (win_done) begin
                        state_nxt = ST_DC_EVAL;
                    end
                end
                ST_DC_EVAL: begin
                    iter_nxt = iter + 1'b1;
                    if ((mid >= MID_LO) && (mid <= MID_HI)) begin
                        dc_store_nxt[ch*DC_W +: DC_W] = dc_reg;
                        pga_nxt   = '0;
                        state_nxt = ST_PGA_WIN;
                    end else begin
                        if (mid < MID_LO) begin
                            dc_nxt = (dc_reg < DC_DN_V) ? '0 : dc_reg - DC_DN_V;
                        end else begin
                            dc_nxt = (dc_reg > (DC_MAX - DC_UP_V)) ? DC_MAX : dc_reg + DC_UP_V;
                        end
                        if (iter == ITER_LAST) begin
                            fail_ch_nxt = ch;
                            state_nxt   = ST_FAIL;
                        end else begin
                            state_nxt = ST_DC_WIN;
                        end
                    end
                end
                ST_PGA_WIN: begin
                    if (win_done) begin
                        state_nxt = ST_PGA_EVAL;
                    end
                end
                ST_PGA_EVAL: begin
                    if (!clip && (pga_reg != PGA_MAX)) begin
                        pga_nxt   = pga_reg + 1'b1;
                        state_nxt = ST_PGA_WIN;
                    end else begin
                        // Clipping backs off one step; reaching full gain clean keeps full gain.
                        pga_store_nxt[ch*PGA_W +: PGA_W] =
                            clip ? ((pga_reg == '0) ? '0 : pga_reg - 1'b1) : pga_reg;
                        pga_nxt   = '0;
                        state_nxt = ST_NEXT_CH;
                    end
                end
                ST_NEXT_CH: begin
                    dc_nxt   = DC_INIT_V;
                    iter_nxt = '0;
                    if (ch == CH_LAST) begin
                        run_ch_nxt = '0;
                        slot_nxt   = '0;
                        state_nxt  = ST_RUN;
                    end else begin
                        ch_nxt    = ch + 1'b1;
                        state_nxt = ST_DC_WIN;
                    end
                end
                ST_RUN: begin
                    // Sample on the last slot cycle so the AFE has settled on the new LED/DC/gain.
                    if (slot_cnt == SLOT_LAST) begin
                        slot_nxt                          = '0;
                        ch_val_nxt[run_ch*ADC_W +: ADC_W] = ADC;
                        ch_vld_nxt[run_ch]                = 1'b1;
                        run_ch_nxt = (run_ch == CH_LAST) ? '0 : run_ch + 1'b1;
                    end else begin
                        slot_nxt = slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // AFE drive: calibration channel during windows, stored settings of the slot channel in RUN
    always_comb begin
        LED_EN   = '0;
        DC_Comp  = dc_reg;
        PGA_Gain = pga_reg;
        if (in_win) begin
            LED_EN[ch] = 1'b1;
        end else if (state == ST_RUN) begin
            LED_EN[run_ch] = 1'b1;
            DC_Comp        = dc_store[run_ch*DC_W +: DC_W];
            PGA_Gain       = pga_store[run_ch*PGA_W +: PGA_W];
        end
    end

    assign CLK_Filter   = clk_filt;
    assign CH_ADC_Value = ch_val;
    assign CH_Valid     = ch_vld;
    assign Calib_done   = (state == ST_RUN);
    assign Calib_fail   = (state == ST_FAIL);
    assign Fail_ch      = fail_ch;

endmodule

// File: tb/tb_afe_multich_calib_ctrl.sv
// Purpose: self-checking bench for afe_multich_calib_ctrl against a rule-level calibration model.
// Latency: n/a (simulation only).
// Backpressure: n/a (simulation only).
module tb_afe_multich_calib_ctrl;

    localparam int N_CH     = 2;
    localparam int WIN_LEN  = 16;
    localparam int SLOT_LEN = 10;
    localparam int MAX_ITER = 64;
    localparam int DC_INIT  = 127;
    localparam int DC_LO    = 120;
    localparam int DC_HI    = 135;
    localparam int DC_DN    = 5;
    localparam int DC_UP    = 2;
    localparam int DC_TOP   = 127;
    localparam int PGA_TOP  = 15;
    localparam int CLIP_LO  = 10;
    localparam int CLIP_HI  = 245;
    localparam int BUDGET   = N_CH * (MAX_ITER + PGA_TOP + 2) * (WIN_LEN + 1) + 100;

    logic        CLK = 1'b0;
    logic        rst;
    logic        Find_setting;
    logic [7:0]  ADC;
    logic [1:0]  LED_EN;
    logic [6:0]  DC_Comp;
    logic [3:0]  PGA_Gain;
    logic        CLK_Filter;
    logic [15:0] CH_ADC_Value;
    logic [1:0]  CH_Valid;
    logic        Calib_done;
    logic        Calib_fail;
    logic [0:0]  Fail_ch;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   tgt[N_CH];
    int   swing[N_CH];
    bit   stuck     = 1'b0;
    bit   run_fixed = 1'b0;
    bit   phase     = 1'b0;
    logic [7:0] prev_adc = 8'h00;
    int   exp_dc[N_CH];
    int   exp_pga[N_CH];
    bit   exp_fail;
    int   exp_fch;

    afe_multich_calib_ctrl #(.WIN_LEN(WIN_LEN)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .ADC          (ADC),
        .Find_setting (Find_setting),
        .LED_EN       (LED_EN),
        .DC_Comp      (DC_Comp),
        .PGA_Gain     (PGA_Gain),
        .CLK_Filter   (CLK_Filter),
        .CH_ADC_Value (CH_ADC_Value),
        .CH_Valid     (CH_Valid),
        .Calib_done   (Calib_done),
        .Calib_fail   (Calib_fail),
        .Fail_ch      (Fail_ch)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Optical front-end: the centre falls 3 LSB per DC code above the channel target, the
    // swing grows with gain, and the signal alternates between its two extremes every cycle.
    function automatic int lvl(input int c_idx, input int dc, input int g, input bit up);
        int c, a, v;
        if (stuck) return 0;
        c = 128 - 3 * (dc - tgt[c_idx]);
        a = swing[c_idx] * (g + 1);
        v = up ? c + a : c - a;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    // Calibration outcome obtained by applying the search rules to the front-end levels.
    function automatic void ref_calib();
        int  dc, g, hi, lo, mid;
        bit  locked, fin, clipped;
        exp_fail = 1'b0;
        exp_fch  = 0;
        for (int c = 0; c < N_CH; c++) begin
            if (!exp_fail) begin
                dc = DC_INIT;
                locked = 1'b0;
                for (int it = 0; it < MAX_ITER; it++) begin
                    if (!locked) begin
                        hi  = lvl(c, dc, 0, 1'b1);
                        lo  = lvl(c, dc, 0, 1'b0);
                        mid = (hi + lo) / 2;
                        if (mid < DC_LO) dc = (dc >= DC_DN) ? dc - DC_DN : 0;
                        else if (mid > DC_HI) dc = (dc + DC_UP > DC_TOP) ? DC_TOP : dc + DC_UP;
                        else locked = 1'b1;
                    end
                end
                if (!locked) begin
                    exp_fail = 1'b1;
                    exp_fch  = c;
                end else begin
                    exp_dc[c] = dc;
                    g   = 0;
                    fin = 1'b0;
                    while (!fin) begin
                        hi = lvl(c, dc, g, 1'b1);
                        lo = lvl(c, dc, g, 1'b0);
                        clipped = (lo < CLIP_LO) || (hi > CLIP_HI);
                        if (!clipped && g < PGA_TOP) g++;
                        else begin
                            exp_pga[c] = clipped ? ((g > 0) ? g - 1 : 0) : g;
                            fin = 1'b1;
                        end
                    end
                end
            end
        end
    endfunction

    // One cycle: remember the ADC value the DUT just sampled, then drive the next one.
    task automatic tick();
        int c;
        @(negedge CLK);
        prev_adc = ADC;
        phase    = ~phase;
        c = LED_EN[1] ? 1 : 0;
        if (stuck) ADC = 8'h00;
        else if (Calib_done) ADC = run_fixed ? ((c == 0) ? 8'h40 : 8'h90) : 8'($urandom_range(0, 255));
        else if (LED_EN != 2'b00) ADC = 8'(lvl(c, int'(DC_Comp), int'(PGA_Gain), phase));
        else ADC = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_find();
        Find_setting = 1'b1;
        tick();
        Find_setting = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!Calib_done && !Calib_fail && n < BUDGET) begin
            tick();
            n++;
        end
        if (!Calib_done && !Calib_fail) check_val("calib_timeout", 32'(0), 32'(1));
    endtask

    // RUN: slot k/SLOT_LEN drives channel (k/SLOT_LEN)%N_CH; a slot's last sample appears with its valid pulse.
    task automatic monitor_run(input string tag, input int nslots);
        int k, vc;
        logic [1:0] vexp;
        for (int r = 0; r <= nslots * SLOT_LEN; r++) begin
            if (r > 0) tick();
            k = (r / SLOT_LEN) % N_CH;
            check_val({tag, "_run_led"}, 32'(LED_EN), 32'(1 << k));
            check_val({tag, "_run_dc"}, 32'(DC_Comp), 32'(exp_dc[k]));
            check_val({tag, "_run_pga"}, 32'(PGA_Gain), 32'(exp_pga[k]));
            vexp = 2'b00;
            vc   = 0;
            if (r > 0 && (r % SLOT_LEN) == 0) begin
                vc   = ((r / SLOT_LEN) - 1) % N_CH;
                vexp = 2'(1 << vc);
            end
            check_val({tag, "_run_vld"}, 32'(CH_Valid), 32'(vexp));
            if (vexp != 2'b00) check_val({tag, "_run_val"}, 32'(CH_ADC_Value[vc*8 +: 8]), 32'(prev_adc));
        end
    endtask

    task automatic check_result(input string tag);
        ref_calib();
        check_val({tag, "_fail"}, 32'(Calib_fail), 32'(exp_fail));
        check_val({tag, "_done"}, 32'(Calib_done), 32'(!exp_fail));
        if (exp_fail) begin
            check_val({tag, "_fail_ch"}, 32'(Fail_ch), 32'(exp_fch));
            check_val({tag, "_fail_led"}, 32'(LED_EN), 32'(0));
        end else if (Calib_done) begin
            monitor_run(tag, 6);
        end
    endtask

    initial begin
        int cf, n;
        rst          = 1'b1;
        Find_setting = 1'b0;
        ADC          = 8'h00;
        tgt[0] = 117; tgt[1] = 97; swing[0] = 20; swing[1] = 5;
        repeat (3) @(negedge CLK);
        rst = 1'b0;

        // Reset state and idle behaviour
        check_val("rst_clkf", 32'(CLK_Filter), 32'(0));
        check_val("rst_dc", 32'(DC_Comp), 32'(DC_INIT));
        check_val("rst_vals", 32'(CH_ADC_Value), 32'(0));
        check_val("rst_fail_ch", 32'(Fail_ch), 32'(0));
        cf = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cf = 1 - cf;
            check_val("idle_led", 32'(LED_EN), 32'(0));
            check_val("idle_dc", 32'(DC_Comp), 32'(DC_INIT));
            check_val("idle_pga", 32'(PGA_Gain), 32'(0));
            check_val("idle_flags", 32'({Calib_done, Calib_fail, CH_Valid}), 32'(0));
            check_val("idle_clkf", 32'(CLK_Filter), 32'(cf));
        end

        // Directed: locks at 117/97, gain clips at 5 on ch0 and never on ch1
        run_fixed = 1'b1;
        pulse_find();
        check_val("start_led", 32'(LED_EN), 32'(1));
        wait_end();
        check_result("directed");
        run_fixed = 1'b0;

        // Randomised targets and swings, including channels that can never lock
        for (int t = 0; t < 5; t++) begin
            tgt[0]   = $urandom_range(30, 127);
            tgt[1]   = $urandom_range(30, 134);
            swing[0] = $urandom_range(0, 40);
            swing[1] = $urandom_range(0, 40);
            pulse_find();
            wait_end();
            check_result("random");
        end

        // ADC stuck low: DC code bottoms out and channel 0 fails
        stuck = 1'b1;
        pulse_find();
        wait_end();
        check_result("stuck");
        check_val("stuck_dc", 32'(DC_Comp), 32'(0));
        stuck = 1'b0;

        // Restart in the middle of channel 1's DC window
        tgt[0] = 117; tgt[1] = 97; swing[0] = 20; swing[1] = 5;
        pulse_find();
        n = 0;
        while (LED_EN != 2'b10 && n < BUDGET) begin
            tick();
            n++;
        end
        check_val("reach_ch1", 32'(LED_EN), 32'(2));
        repeat (5) tick();
        pulse_find();
        check_val("mid_restart_led", 32'(LED_EN), 32'(1));
        check_val("mid_restart_dc", 32'(DC_Comp), 32'(DC_INIT));
        check_val("mid_restart_pga", 32'(PGA_Gain), 32'(0));
        wait_end();
        check_result("restart_ch1");

        // Restart while running
        repeat (3) tick();
        pulse_find();
        check_val("run_restart_done", 32'(Calib_done), 32'(0));
        check_val("run_restart_led", 32'(LED_EN), 32'(1));
        check_val("run_restart_dc", 32'(DC_Comp), 32'(DC_INIT));
        check_val("run_restart_vld", 32'(CH_Valid), 32'(0));
        wait_end();
        check_result("restart_run");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
